// File: rtl/hdcpu_int_pkg.sv
// Shared constants, types and the lowest-set-bit priority encoder for the HD-CPU interrupt controller.
package hdcpu_int_pkg;

  localparam int unsigned N_IRQ_MAX      = 8;
  localparam int unsigned IDX_W          = 3;
  localparam int unsigned VEC_BASE_DEF   = 32'h0000_00F0;
  localparam int unsigned VEC_STRIDE_DEF = 2;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } prio_t;

  // Lowest-index set bit wins; index 0 is the highest priority.
  function automatic prio_t lowest_set(input logic [N_IRQ_MAX-1:0] v);
    prio_t r;
    r = '0;
    for (int i = int'(N_IRQ_MAX) - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hdcpu_irq_sync.sv
// Per-channel request conditioning: 2-flop synchroniser, history flop and a one-cycle rising-edge pulse.
module hdcpu_irq_sync (
  input  logic T3,
  input  logic CLR,
  input  logic irq,
  output logic rise_c
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(negedge T3) begin
    if (CLR) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise_c = sync2 & ~hist;

endmodule

// File: rtl/hdcpu_int_ctrl.sv
// Priority interrupt controller for the HD-CPU hardwired controller; state advances on the falling edge of T3.
// Define HDCPU_INT_NEST_EN to let a higher-priority channel preempt an active service routine.
module hdcpu_int_ctrl
  import hdcpu_int_pkg::*;
#(
  parameter int unsigned N_IRQ      = 4,
  parameter int unsigned VEC_W      = 8,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic [N_IRQ-1:0] IRQ,
  input  logic             MASK_WE,
  input  logic [N_IRQ-1:0] MASK_D,
  input  logic             EI_SET,
  input  logic             EI_CLR,
  input  logic             INT_ACK,
  input  logic             IRET,
  output logic             INT_REQ,
  output logic [VEC_W-1:0] VEC,
  output logic [N_IRQ-1:0] PEND,
  output logic [N_IRQ-1:0] ISR,
  output logic             EI
);

  logic [N_IRQ-1:0] irq_rise;
  logic [N_IRQ-1:0] pend, pend_n;
  logic [N_IRQ-1:0] isr, isr_n;
  logic [N_IRQ-1:0] mask, mask_n;
  logic             ei, ei_n;
  logic [VEC_W-1:0] vec, vec_n;

  prio_t            cand;
  prio_t            isr_lo;
  logic [N_IRQ-1:0] isr_mid;
  logic             ei_mid;
  logic             req_mid;
  logic             take;
`ifdef HDCPU_INT_NEST_EN
  prio_t            mid_lo;
`endif

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    hdcpu_irq_sync u_sync (
      .T3     (T3),
      .CLR    (CLR),
      .irq    (IRQ[g]),
      .rise_c (irq_rise[g])
    );
  end

  // Visible candidate and the active service level.
  always_comb begin : decode
    cand   = lowest_set(N_IRQ_MAX'(pend & ~mask));
    isr_lo = lowest_set(N_IRQ_MAX'(isr));
  end

`ifdef HDCPU_INT_NEST_EN
  assign INT_REQ = ei & cand.valid & (~isr_lo.valid | (cand.idx < isr_lo.idx));
`else
  assign INT_REQ = ei & cand.valid & ~isr_lo.valid;
`endif

  // IRET retires first, then INT_ACK is judged against the post-IRET view.
  always_comb begin : next_state
    pend_n  = pend;
    isr_n   = isr;
    mask_n  = mask;
    ei_n    = ei;
    vec_n   = vec;
    isr_mid = isr;
    ei_mid  = ei;
    req_mid = 1'b0;
    take    = 1'b0;
`ifdef HDCPU_INT_NEST_EN
    mid_lo  = '0;
`endif

    if (IRET) begin
      isr_mid = isr & ~(N_IRQ'(1) << isr_lo.idx);
      ei_mid  = 1'b1;
    end

`ifdef HDCPU_INT_NEST_EN
    mid_lo  = lowest_set(N_IRQ_MAX'(isr_mid));
    req_mid = ei_mid & cand.valid & (~mid_lo.valid | (cand.idx < mid_lo.idx));
`else
    req_mid = ei_mid & cand.valid & ~(|isr_mid);
`endif

    take  = INT_ACK & req_mid;
    isr_n = isr_mid;

    if (IRET || EI_SET) begin
      ei_n = 1'b1;
    end
    if (EI_CLR || take) begin
      ei_n = 1'b0;
    end

    if (take) begin
      vec_n  = VEC_W'(VEC_BASE + 32'(cand.idx) * VEC_STRIDE);
      isr_n  = isr_mid | (N_IRQ'(1) << cand.idx);
      pend_n = pend & ~(N_IRQ'(1) << cand.idx);
    end
    // A fresh edge on the acknowledged channel keeps it pending.
    pend_n = pend_n | irq_rise;

    if (MASK_WE) begin
      mask_n = MASK_D;
    end
  end

  always_ff @(negedge T3) begin
    if (CLR) begin
      pend <= '0;
      isr  <= '0;
      mask <= '1;
      ei   <= 1'b0;
      vec  <= '0;
    end else begin
      pend <= pend_n;
      isr  <= isr_n;
      mask <= mask_n;
      ei   <= ei_n;
      vec  <= vec_n;
    end
  end

  assign PEND = pend;
  assign ISR  = isr;
  assign EI   = ei;
  assign VEC  = vec;

endmodule

// File: tb/tb_hdcpu_int_ctrl.sv
// Self-checking bench for hdcpu_int_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hdcpu_int_ctrl;

  localparam int unsigned N = 4;

  logic         T3 = 1'b0;
  logic         CLR = 1'b0;
  logic [N-1:0] IRQ = '0;
  logic         MASK_WE = 1'b0;
  logic [N-1:0] MASK_D = '0;
  logic         EI_SET = 1'b0;
  logic         EI_CLR = 1'b0;
  logic         INT_ACK = 1'b0;
  logic         IRET = 1'b0;
  logic         INT_REQ;
  logic [7:0]   VEC;
  logic [N-1:0] PEND;
  logic [N-1:0] ISR;
  logic         EI;

  int n_pass  = 0;
  int n_total = 0;

  hdcpu_int_ctrl #(
    .N_IRQ      (N),
    .VEC_W      (8),
    .VEC_BASE   (32'hF0),
    .VEC_STRIDE (2)
  ) dut (
    .T3      (T3),
    .CLR     (CLR),
    .IRQ     (IRQ),
    .MASK_WE (MASK_WE),
    .MASK_D  (MASK_D),
    .EI_SET  (EI_SET),
    .EI_CLR  (EI_CLR),
    .INT_ACK (INT_ACK),
    .IRET    (IRET),
    .INT_REQ (INT_REQ),
    .VEC     (VEC),
    .PEND    (PEND),
    .ISR     (ISR),
    .EI      (EI)
  );

  always #5 T3 = ~T3;

  // Behavioural model state
  logic [N-1:0] m_pend, m_isr, m_mask;
  logic         m_ei;
  logic [7:0]   m_vec;
  logic [N-1:0] m_samples[$];

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic m_req(input logic [N-1:0] pend, input logic [N-1:0] mask,
                                 input logic [N-1:0] isr, input logic ei);
    int c;
    int l;
    c = lowest(pend & ~mask);
    l = lowest(isr);
    if (!ei || c < 0) return 1'b0;
`ifdef HDCPU_INT_NEST_EN
    return (l < 0) || (c < l);
`else
    return l < 0;
`endif
  endfunction

  task automatic model_reset();
    m_pend = '0; m_isr = '0; m_mask = '1; m_ei = 1'b0; m_vec = '0;
    m_samples = {};
    repeat (4) m_samples.push_front('0);
  endtask

  // A request is seen as a rise when its sample two edges ago is 1 and three edges ago is 0.
  task automatic model_step();
    logic [N-1:0] rise;
    logic [N-1:0] isr_after;
    logic         ei_after;
    logic         ei_new;
    logic         take;
    int c;
    int l;
    if (CLR) begin
      model_reset();
      return;
    end
    m_samples.push_front(IRQ);
    rise = m_samples[2] & ~m_samples[3];
    void'(m_samples.pop_back());
    isr_after = m_isr;
    ei_after  = m_ei;
    if (IRET) begin
      l = lowest(m_isr);
      if (l >= 0) isr_after[l] = 1'b0;
      ei_after = 1'b1;
    end
    take = INT_ACK && m_req(m_pend, m_mask, isr_after, ei_after);
    c = lowest(m_pend & ~m_mask);
    ei_new = m_ei;
    if (IRET || EI_SET) ei_new = 1'b1;
    if (EI_CLR || take) ei_new = 1'b0;
    if (take) begin
      m_vec        = 8'((240 + c * 2) % 256);
      isr_after[c] = 1'b1;
      m_pend[c]    = 1'b0;
    end
    m_pend = m_pend | rise;
    m_isr  = isr_after;
    m_ei   = ei_new;
    if (MASK_WE) m_mask = MASK_D;
  endtask

  // One falling-edge update; returns one half period later, clear of the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge T3);
      model_step();
      @(posedge T3);
      #1;
    end
  endtask

  task automatic test_reset();
    CLR = 1'b1; tick(); CLR = 1'b0;
    n_total++; if (PEND !== 4'b0000) $display("FAIL reset_pend: got %b want 0000", PEND); else n_pass++;
    n_total++; if (ISR !== 4'b0000) $display("FAIL reset_isr: got %b want 0000", ISR); else n_pass++;
    n_total++; if (EI !== 1'b0) $display("FAIL reset_ei: got %b want 0", EI); else n_pass++;
    n_total++; if (VEC !== 8'h00) $display("FAIL reset_vec: got %h want 00", VEC); else n_pass++;
    n_total++; if (INT_REQ !== 1'b0) $display("FAIL reset_int_req: got %b want 0", INT_REQ); else n_pass++;
  endtask

  task automatic test_single();
    MASK_WE = 1'b1; MASK_D = 4'b0000; tick(); MASK_WE = 1'b0;
    EI_SET = 1'b1; tick(); EI_SET = 1'b0;
    n_total++; if (EI !== 1'b1) $display("FAIL single_ei_set: got %b want 1", EI); else n_pass++;
    IRQ = 4'b0100; tick(2);
    n_total++; if (PEND !== 4'b0000) $display("FAIL single_pend_early: got %b want 0000", PEND); else n_pass++;
    tick();
    n_total++; if (PEND !== 4'b0100) $display("FAIL single_pend: got %b want 0100", PEND); else n_pass++;
    n_total++; if (INT_REQ !== 1'b1) $display("FAIL single_int_req: got %b want 1", INT_REQ); else n_pass++;
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    n_total++; if (VEC !== 8'hF4) $display("FAIL single_vec: got %h want f4", VEC); else n_pass++;
    n_total++; if (ISR !== 4'b0100) $display("FAIL single_isr: got %b want 0100", ISR); else n_pass++;
    n_total++; if (EI !== 1'b0) $display("FAIL single_ei_ack: got %b want 0", EI); else n_pass++;
    n_total++; if (PEND !== 4'b0000) $display("FAIL single_pend_ack: got %b want 0000", PEND); else n_pass++;
    n_total++; if (INT_REQ !== 1'b0) $display("FAIL single_req_ack: got %b want 0", INT_REQ); else n_pass++;
    IRQ = '0; IRET = 1'b1; tick(); IRET = 1'b0;
    n_total++; if (ISR !== 4'b0000) $display("FAIL single_iret_isr: got %b want 0000", ISR); else n_pass++;
    n_total++; if (EI !== 1'b1) $display("FAIL single_iret_ei: got %b want 1", EI); else n_pass++;
    tick(3);
  endtask

  task automatic test_priority();
    IRQ = 4'b1010; tick(3);
    n_total++; if (PEND !== 4'b1010) $display("FAIL prio_pend: got %b want 1010", PEND); else n_pass++;
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    n_total++; if (VEC !== 8'hF2) $display("FAIL prio_vec1: got %h want f2", VEC); else n_pass++;
    n_total++; if (PEND !== 4'b1000) $display("FAIL prio_pend1: got %b want 1000", PEND); else n_pass++;
    IRET = 1'b1; tick(); IRET = 1'b0;
    n_total++; if (INT_REQ !== 1'b1) $display("FAIL prio_req_after_iret: got %b want 1", INT_REQ); else n_pass++;
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    n_total++; if (VEC !== 8'hF6) $display("FAIL prio_vec2: got %h want f6", VEC); else n_pass++;
    n_total++; if (ISR !== 4'b1000) $display("FAIL prio_isr2: got %b want 1000", ISR); else n_pass++;
    IRQ = '0; IRET = 1'b1; tick(); IRET = 1'b0;
    tick(3);
  endtask

  task automatic test_masking();
    MASK_WE = 1'b1; MASK_D = 4'b0001; tick(); MASK_WE = 1'b0;
    IRQ = 4'b0001; tick(3);
    n_total++; if (PEND !== 4'b0001) $display("FAIL mask_pend: got %b want 0001", PEND); else n_pass++;
    n_total++; if (INT_REQ !== 1'b0) $display("FAIL mask_req_hidden: got %b want 0", INT_REQ); else n_pass++;
    MASK_WE = 1'b1; MASK_D = 4'b0000; tick(); MASK_WE = 1'b0;
    n_total++; if (INT_REQ !== 1'b1) $display("FAIL mask_req_unmasked: got %b want 1", INT_REQ); else n_pass++;
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    n_total++; if (VEC !== 8'hF0) $display("FAIL mask_vec: got %h want f0", VEC); else n_pass++;
    IRQ = '0; IRET = 1'b1; tick(); IRET = 1'b0;
    tick(3);
  endtask

  task automatic test_nesting();
    IRQ = 4'b0100; tick(3);
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    IRQ = '0; EI_SET = 1'b1; tick(); EI_SET = 1'b0;
    n_total++; if (ISR !== 4'b0100) $display("FAIL nest_isr_setup: got %b want 0100", ISR); else n_pass++;
    IRQ = 4'b0001; tick(3);
`ifdef HDCPU_INT_NEST_EN
    n_total++; if (INT_REQ !== 1'b1) $display("FAIL nest_req: got %b want 1", INT_REQ); else n_pass++;
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    n_total++; if (ISR !== 4'b0101) $display("FAIL nest_isr_both: got %b want 0101", ISR); else n_pass++;
    IRET = 1'b1; tick(); IRET = 1'b0;
    n_total++; if (ISR !== 4'b0100) $display("FAIL nest_iret_order: got %b want 0100", ISR); else n_pass++;
    IRET = 1'b1; tick(); IRET = 1'b0;
`else
    n_total++; if (INT_REQ !== 1'b0) $display("FAIL nest_req: got %b want 0", INT_REQ); else n_pass++;
    IRET = 1'b1; tick(); IRET = 1'b0;
    n_total++; if (INT_REQ !== 1'b1) $display("FAIL nest_req_after_iret: got %b want 1", INT_REQ); else n_pass++;
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    n_total++; if (VEC !== 8'hF0) $display("FAIL nest_vec: got %h want f0", VEC); else n_pass++;
    IRET = 1'b1; tick(); IRET = 1'b0;
`endif
    n_total++; if (ISR !== 4'b0000) $display("FAIL nest_isr_done: got %b want 0000", ISR); else n_pass++;
    IRQ = '0; tick(3);
  endtask

  task automatic test_simultaneous();
    EI_SET = 1'b1; EI_CLR = 1'b1; tick(); EI_SET = 1'b0; EI_CLR = 1'b0;
    n_total++; if (EI !== 1'b0) $display("FAIL simul_ei_clr_wins: got %b want 0", EI); else n_pass++;
    EI_SET = 1'b1; tick(); EI_SET = 1'b0;
    IRQ = 4'b0100; tick();
    IRQ = 4'b0000; tick();
    IRQ = 4'b0100; tick();
    n_total++; if (INT_REQ !== 1'b1) $display("FAIL simul_req: got %b want 1", INT_REQ); else n_pass++;
    tick();
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    n_total++; if (PEND !== 4'b0100) $display("FAIL simul_pend_kept: got %b want 0100", PEND); else n_pass++;
    n_total++; if (ISR !== 4'b0100) $display("FAIL simul_isr: got %b want 0100", ISR); else n_pass++;
    IRQ = '0; IRET = 1'b1; tick(); IRET = 1'b0;
    n_total++; if (INT_REQ !== 1'b1) $display("FAIL simul_retrigger_req: got %b want 1", INT_REQ); else n_pass++;
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    IRET = 1'b1; tick(); IRET = 1'b0;
    n_total++; if (PEND !== 4'b0000) $display("FAIL simul_pend_clear: got %b want 0000", PEND); else n_pass++;
  endtask

  task automatic test_clr_mid_service();
    IRQ = 4'b0110; tick(3);
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    n_total++; if (ISR !== 4'b0010) $display("FAIL clr_isr_setup: got %b want 0010", ISR); else n_pass++;
    IRQ = '0; CLR = 1'b1; tick(); CLR = 1'b0;
    n_total++; if (PEND !== 4'b0000) $display("FAIL clr_pend: got %b want 0000", PEND); else n_pass++;
    n_total++; if (ISR !== 4'b0000) $display("FAIL clr_isr: got %b want 0000", ISR); else n_pass++;
    n_total++; if (EI !== 1'b0) $display("FAIL clr_ei: got %b want 0", EI); else n_pass++;
    n_total++; if (VEC !== 8'h00) $display("FAIL clr_vec: got %h want 00", VEC); else n_pass++;
    EI_SET = 1'b1; tick(); EI_SET = 1'b0;
    IRQ = 4'b1111; tick(3);
    n_total++; if (PEND !== 4'b1111) $display("FAIL clr_mask_pend: got %b want 1111", PEND); else n_pass++;
    n_total++; if (INT_REQ !== 1'b0) $display("FAIL clr_mask_all_ones: got %b want 0", INT_REQ); else n_pass++;
    IRQ = '0;
  endtask

  task automatic test_random();
    CLR = 1'b1; tick(); CLR = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int b = 0; b < int'(N); b++) if ($urandom_range(0, 4) == 0) IRQ[b] = ~IRQ[b];
      CLR     = ($urandom_range(0, 79) == 0);
      MASK_WE = ($urandom_range(0, 7) == 0);
      MASK_D  = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      EI_SET  = ($urandom_range(0, 3) == 0);
      EI_CLR  = ($urandom_range(0, 9) == 0);
      INT_ACK = ($urandom_range(0, 2) == 0);
      IRET    = ($urandom_range(0, 5) == 0);
      tick();
      n_total++; if (PEND !== m_pend) $display("FAIL rand_pend cyc %0d: got %b want %b", cyc, PEND, m_pend); else n_pass++;
      n_total++; if (ISR !== m_isr) $display("FAIL rand_isr cyc %0d: got %b want %b", cyc, ISR, m_isr); else n_pass++;
      n_total++; if (EI !== m_ei) $display("FAIL rand_ei cyc %0d: got %b want %b", cyc, EI, m_ei); else n_pass++;
      n_total++; if (VEC !== m_vec) $display("FAIL rand_vec cyc %0d: got %h want %h", cyc, VEC, m_vec); else n_pass++;
      n_total++;
      if (INT_REQ !== m_req(m_pend, m_mask, m_isr, m_ei))
        $display("FAIL rand_int_req cyc %0d: got %b want %b", cyc, INT_REQ, m_req(m_pend, m_mask, m_isr, m_ei));
      else n_pass++;
    end
    CLR = 1'b0; MASK_WE = 1'b0; EI_SET = 1'b0; EI_CLR = 1'b0; INT_ACK = 1'b0; IRET = 1'b0; IRQ = '0;
  endtask

  initial begin
    model_reset();
    @(posedge T3); #1;
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_nesting();
    test_simultaneous();
    test_clr_mid_service();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
